// File: rtl/scarv_cop_pkg.sv
// Shared types and constants for the SCARV coprocessor issue stage.
package scarv_cop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_ABORT    = 3'd3,
    ST_WB       = 3'd4
  } state_e;

  localparam logic [2:0]  RESULT_OK       = 3'b000;
  localparam logic [2:0]  RESULT_TIMEOUT  = 3'b111;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  result;
  } wb_t;

endpackage

// File: rtl/scarv_cop_issue_if.sv
// Request/response bus between the issue stage (master) and the coprocessor (slave).
interface scarv_cop_issue_if;
  import scarv_cop_pkg::*;

  logic        cpu_insn_req;
  logic        cpu_abort_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_insn_ack;
  logic        cop_insn_rsp;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;

  modport master (
    output cpu_insn_req, cpu_abort_req, cpu_insn_ack, cpu_insn_enc, cpu_rs1,
    input  cop_insn_ack, cop_insn_rsp, cop_wen, cop_waddr, cop_wdata, cop_result
  );

  modport slave (
    input  cpu_insn_req, cpu_abort_req, cpu_insn_ack, cpu_insn_enc, cpu_rs1,
    output cop_insn_ack, cop_insn_rsp, cop_wen, cop_waddr, cop_wdata, cop_result
  );

endinterface

// File: rtl/scarv_cop_watchdog.sv
// 16-bit response watchdog: cleared on state entry, counts while enabled.
module scarv_cop_watchdog
  import scarv_cop_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d; no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    // NOTE: non-blocking here; blocking stays in always_comb only.
    if (!g_resetn) count_q <= '0;
    else           count_q <= count_d;
  end

  // count_q is the number of cycles already spent, so the limit-th cycle expires.
  assign expired = enable && (count_q == limit - 16'd1);

endmodule

// File: rtl/scarv_cop_issue.sv
// Issues one COP instruction at a time, handles flush/abort and watchdog timeout.
module scarv_cop_issue
  import scarv_cop_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_insn,
  input  logic [31:0] dec_rs1,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_wen,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic [2:0]  wb_result,
  scarv_cop_issue_if.master cop
);

  state_e      state_q, state_d;
  logic        acked_q, acked_d;
  logic        cpu_insn_req_q, cpu_insn_req_d;
  logic        cpu_abort_req_q, cpu_abort_req_d;
  logic        cpu_insn_ack_q, cpu_insn_ack_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] cpu_insn_enc_q, cpu_insn_enc_d;
  logic [31:0] cpu_rs1_q, cpu_rs1_d;
  wb_t         wb_q, wb_d;

  logic wd_clear, wd_enable, wd_expired;
  logic rsp_ok;

  // A response arriving while the previous one is still being acknowledged is ignored.
  assign rsp_ok = cop.cop_insn_rsp && !cpu_insn_ack_q;

  always_comb begin
    state_d         = state_q;
    acked_d         = acked_q;
    cpu_insn_req_d  = cpu_insn_req_q;
    cpu_abort_req_d = cpu_abort_req_q;
    cpu_insn_ack_d  = 1'b0;
    wb_valid_d      = wb_valid_q;
    cpu_insn_enc_d  = cpu_insn_enc_q;
    cpu_rs1_d       = cpu_rs1_q;
    wb_d            = wb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dec_valid && !flush) begin
          cpu_insn_enc_d = dec_insn;
          cpu_rs1_d      = dec_rs1;
          cpu_insn_req_d = 1'b1;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) begin
          // The request must still be accepted; remember whether it already was.
          cpu_abort_req_d = 1'b1;
          acked_d         = cop.cop_insn_ack;
          cpu_insn_req_d  = !cop.cop_insn_ack;
          state_d         = ST_ABORT;
        end else if (cop.cop_insn_ack) begin
          cpu_insn_req_d = 1'b0;
          state_d        = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_ok) begin
          wb_d           = '{wen: cop.cop_wen, waddr: cop.cop_waddr,
                             wdata: cop.cop_wdata, result: cop.cop_result};
          cpu_insn_ack_d = 1'b1;
          wb_valid_d     = 1'b1;
          state_d        = ST_WB;
        end else if (flush) begin
          cpu_abort_req_d = 1'b1;
          acked_d         = 1'b1;
          state_d         = ST_ABORT;
        end else if (wd_expired) begin
          wb_d       = '{wen: 1'b0, waddr: '0, wdata: '0, result: RESULT_TIMEOUT};
          wb_valid_d = 1'b1;
          state_d    = ST_WB;
        end
      end
      ST_ABORT: begin
        if (acked_q && rsp_ok) begin
          cpu_insn_ack_d  = 1'b1;
          cpu_abort_req_d = 1'b0;
          acked_d         = 1'b0;
          state_d         = ST_IDLE;
        end else if (wd_expired) begin
          cpu_abort_req_d = 1'b0;
          cpu_insn_req_d  = 1'b0;
          acked_d         = 1'b0;
          state_d         = ST_IDLE;
        end else if (!acked_q && cop.cop_insn_ack) begin
          acked_d        = 1'b1;
          cpu_insn_req_d = 1'b0;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q         <= ST_IDLE;
      acked_q         <= 1'b0;
      cpu_insn_req_q  <= 1'b0;
      cpu_abort_req_q <= 1'b0;
      cpu_insn_ack_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      cpu_insn_enc_q  <= '0;
      cpu_rs1_q       <= '0;
      wb_q            <= '{wen: 1'b0, waddr: '0, wdata: '0, result: RESULT_OK};
    end else begin
      state_q         <= state_d;
      acked_q         <= acked_d;
      cpu_insn_req_q  <= cpu_insn_req_d;
      cpu_abort_req_q <= cpu_abort_req_d;
      cpu_insn_ack_q  <= cpu_insn_ack_d;
      wb_valid_q      <= wb_valid_d;
      cpu_insn_enc_q  <= cpu_insn_enc_d;
      cpu_rs1_q       <= cpu_rs1_d;
      wb_q            <= wb_d;
    end
  end

  assign wd_enable = (state_q == ST_WAIT_RSP) || (state_q == ST_ABORT);
  assign wd_clear  = (state_d != state_q) &&
                     ((state_d == ST_WAIT_RSP) || (state_d == ST_ABORT));

  scarv_cop_watchdog u_watchdog (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .limit    (16'(TIMEOUT)),
    .expired  (wd_expired)
  );

  assign dec_ready         = (state_q == ST_IDLE);
  assign wb_valid          = wb_valid_q;
  assign wb_wen            = wb_q.wen;
  assign wb_waddr          = wb_q.waddr;
  assign wb_wdata          = wb_q.wdata;
  assign wb_result         = wb_q.result;
  assign cop.cpu_insn_req  = cpu_insn_req_q;
  assign cop.cpu_abort_req = cpu_abort_req_q;
  assign cop.cpu_insn_ack  = cpu_insn_ack_q;
  assign cop.cpu_insn_enc  = cpu_insn_enc_q;
  assign cop.cpu_rs1       = cpu_rs1_q;

endmodule
